vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA output path. Samples hsync, vsync and 12-bit RGB at pixel rate.
- Recovers horizontal and vertical position from the sync edges alone and checks the measured timing against the expected mode.
- Reports lock status and an error count, and produces a per-frame checksum of active-area pixels.
- Used as an on-chip loopback checker and as a bench scoreboard for the renderer.

Parameters:
H_TOTAL, 800, expected pixel ticks per line
H_SYNC, 96, expected hsync pulse width (ticks)
H_BP, 48, back porch ticks after the hsync pulse
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, expected lines per frame
V_SYNC, 2, expected vsync pulse width (lines)
V_BP, 33, back porch lines after the vsync pulse
V_ACTIVE, 480, active lines per frame
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-low reset
pix_en  in  1  pixel-rate strobe; all inputs are sampled only when pix_en=1
hsync  in  1  horizontal sync from the renderer
vsync  in  1  vertical sync from the renderer
red  in  4  pixel red
green  in  4  pixel green
blue  in  4  pixel blue
locked  out  1  timing matches the parameters
frame_done  out  1  one-clk pulse at each frame boundary while LOCKED
frame_sum  out  16  checksum of the last complete locked frame
frame_cnt  out  16  count of frame_done pulses (wraps)
h_total_meas  out  11  last measured line length
hs_width_meas  out  11  last measured hsync width
v_total_meas  out  10  last measured lines per frame
vs_width_meas  out  10  last measured vsync width (lines)
err_cnt  out  8  timing errors while LOCKED (saturates at 255)

Behaviour:
- Reset: while clr=0 at a clk edge, every output is 0, the state is SEARCH and all internal counters and registers are 0.
- Sampling: "asserted" means the sync level equals SYNC_POL. The previous sync levels are registered on each pix_en sample. Asserting and deasserting edges are found by comparing against those registered levels.
- pix_en=0: nothing changes except that frame_done returns to 0.
- Horizontal counter h_cnt (11b):
  - On an hsync asserting edge: h_total_meas <= h_cnt+1, then h_cnt <= 0.
  - Otherwise h_cnt increments on each sample.
  - On an hsync deasserting edge: hs_width_meas <= h_cnt.
- Line counter l_cnt (10b):
  - On a vsync asserting edge: v_total_meas <= l_cnt+1, then l_cnt <= 0. This takes priority over a coincident hsync edge, which then does not increment l_cnt.
  - Otherwise l_cnt increments on each hsync asserting edge.
  - On a vsync deasserting edge: vs_width_meas <= l_cnt.
- Active window: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and l_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Checksum: in MEASURE and LOCKED, sum <= sum + {4'b0,red,green,blue} (mod 2^16) on each active sample.
- Watchdog: wd counts samples since the last hsync asserting edge. When wd reaches 2*H_TOTAL, go to SEARCH; if the state was LOCKED, err_cnt increments.
- State SEARCH: locked=0, sum held at 0. A vsync asserting edge moves to MEASURE with frame_ok=1 and sum=0.
- State MEASURE: locked=0.
  - Any h_total, hs_width or vs_width measurement different from its parameter clears frame_ok.
  - At the next vsync asserting edge: if frame_ok is 1 and v_total equals V_TOTAL, go to LOCKED. Otherwise stay in MEASURE.
  - In either case at that edge: frame_ok <= 1 and sum <= 0.
- State LOCKED: locked=1.
  - At each vsync asserting edge: frame_sum <= sum, sum <= 0, frame_done=1 for one clk, frame_cnt++.
  - Any measurement mismatch, including v_total: err_cnt++ (saturating), go to SEARCH, locked drops the same cycle the state changes. No frame_done is issued for a frame that ends on a v_total mismatch.
- The first hsync edge after entering SEARCH or MEASURE gives a partial-line measurement. It is ignored for frame_ok, and the first vsync edge after SEARCH is not checked.
- Latency: measured registers update on the clk edge of the sync edge sample. The locked and frame_done transitions occur on that same edge.

Decomposition:
- Shared package vga_pkg holds:
  - the mode constants (H_/V_ defaults)
  - the state enum {SEARCH, MEASURE, LOCKED}
  - the derived window bounds
- One sub-module, sync_edge_meter, is instantiated twice (horizontal counting ticks, vertical counting lines). It takes an enable, a sync input and a count enable, and outputs the edge strobes, count, total and width.

Test Plan:
- Nominal mode, continuous pix_en, 3 frames -> locked=1 after the 2nd vsync edge; h_total_meas=800, hs_width_meas=96, v_total_meas=525, vs_width_meas=2; err_cnt=0.
- Constant RGB 12'h001 -> frame_sum=16'hB000 at every frame_done; frame_cnt increments by 1 per frame.
- While locked, one line stretched to 801 ticks -> locked falls on that hsync edge, err_cnt=1, state returns to LOCKED two vsync edges later.
- hsync held deasserted while locked -> 1600 samples after the last edge: locked=0, err_cnt+1.
- clr=0 mid-frame for one clk -> all outputs 0; relock after 2 further vsync edges.
- pix_en active on every 4th clk versus continuous -> identical measurements and frame_sum; frame_done is exactly 1 clk wide.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared mode constants, state encoding and window helpers
// for the VGA sync monitor.
package vga_pkg;

    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;

    typedef logic [1:0] state_t;

    localparam state_t SEARCH  = 2'd0;
    localparam state_t MEASURE = 2'd1;
    localparam state_t LOCKED  = 2'd2;

    // First active position after sync pulse plus back porch
    function automatic int win_lo(input int s, input int b);
        return s + b;
    endfunction

    // Last active position
    function automatic int win_hi(input int s, input int b, input int a);
        return s + b + a - 1;
    endfunction

    localparam int DEF_H_LO = win_lo(DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_H_HI = win_hi(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE);
    localparam int DEF_V_LO = win_lo(DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_V_HI = win_hi(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE);

endpackage

// File: rtl/sync_edge_meter.sv
// Edge detector plus position counter for one sync axis;
// measures period (edge to edge) and pulse width.
module sync_edge_meter #(
    parameter int   W   = 11,
    parameter logic POL = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         sync,
    input  logic         cnt_en,
    output logic         rise,
    output logic         fall,
    output logic [W-1:0] pos,
    output logic [W-1:0] len,
    output logic [W-1:0] total,
    output logic [W-1:0] width
);

    logic         prev;
    logic [W-1:0] cnt;
    logic         act;
    logic         prev_act;

    assign act      = (sync == POL);
    assign prev_act = (prev == POL);
    assign rise     = en && act && !prev_act;
    assign fall     = en && !act && prev_act;

    // len: period if an asserting edge lands on this sample.
    // pos: position of the current sample (0 at the edge).
    assign len = cnt + W'(1);
    assign pos = rise ? '0 : (cnt_en ? len : cnt);

    // Track previous level, position and latch measurements
    always_ff @(posedge clk) begin
        if (!clr) begin
            prev  <= 1'b0;
            cnt   <= '0;
            total <= '0;
            width <= '0;
        end else if (en) begin
            prev <= sync;
            cnt  <= pos;
            if (rise)
                total <= len;
            if (fall)
                width <= pos;
        end
    end

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers position from sync
// edges, tracks lock, counts errors and checksums active pixels.
module vga_sync_monitor
    import vga_pkg::*;
#(
    parameter int   H_TOTAL  = DEF_H_TOTAL,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   V_TOTAL  = DEF_V_TOTAL,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_cnt,
    output logic [10:0] h_total_meas,
    output logic [10:0] hs_width_meas,
    output logic [9:0]  v_total_meas,
    output logic [9:0]  vs_width_meas,
    output logic [7:0]  err_cnt
);

    localparam int WDW = $clog2(2 * H_TOTAL + 1);

    localparam logic [10:0] H_TOT_C = 11'(H_TOTAL);
    localparam logic [10:0] H_SYN_C = 11'(H_SYNC);
    localparam logic [9:0]  V_TOT_C = 10'(V_TOTAL);
    localparam logic [9:0]  V_SYN_C = 10'(V_SYNC);

    localparam logic [10:0] H_LO = 11'(win_lo(H_SYNC, H_BP));
    localparam logic [10:0] H_HI = 11'(win_hi(H_SYNC, H_BP, H_ACTIVE));
    localparam logic [9:0]  V_LO = 10'(win_lo(V_SYNC, V_BP));
    localparam logic [9:0]  V_HI = 10'(win_hi(V_SYNC, V_BP, V_ACTIVE));

    localparam logic [WDW-1:0] WD_MAX = WDW'(2 * H_TOTAL);
    localparam logic [WDW-1:0] WD_HIT = WDW'(2 * H_TOTAL - 1);

    state_t         state;
    logic           frame_ok;
    logic           h_valid;
    logic [15:0]    sum;
    logic [WDW-1:0] wd;

    logic        h_rise;
    logic        h_fall;
    logic [10:0] h_pos;
    logic [10:0] h_len;
    logic        v_rise;
    logic        v_fall;
    logic [9:0]  l_pos;
    logic [9:0]  v_len;

    sync_edge_meter #(.W(11), .POL(SYNC_POL)) u_h (
        .clk    (clk),
        .clr    (clr),
        .en     (pix_en),
        .sync   (hsync),
        .cnt_en (1'b1),
        .rise   (h_rise),
        .fall   (h_fall),
        .pos    (h_pos),
        .len    (h_len),
        .total  (h_total_meas),
        .width  (hs_width_meas)
    );

    sync_edge_meter #(.W(10), .POL(SYNC_POL)) u_v (
        .clk    (clk),
        .clr    (clr),
        .en     (pix_en),
        .sync   (vsync),
        .cnt_en (h_rise),
        .rise   (v_rise),
        .fall   (v_fall),
        .pos    (l_pos),
        .len    (v_len),
        .total  (v_total_meas),
        .width  (vs_width_meas)
    );

    logic h_tot_bad;
    logic hs_bad;
    logic vs_bad;
    logic vt_bad;
    logic meas_bad;
    logic wd_hit;
    logic active;

    // Line measurements are trusted only after one full line in
    // the current state, so a partial first line is not an error.
    assign h_tot_bad = h_rise && (h_len != H_TOT_C);
    assign hs_bad    = h_fall && (h_pos != H_SYN_C);
    assign vs_bad    = v_fall && (l_pos != V_SYN_C);
    assign vt_bad    = v_rise && (v_len != V_TOT_C);
    assign meas_bad  = (h_valid && (h_tot_bad || hs_bad)) || vs_bad;
    assign wd_hit    = !h_rise && (wd == WD_HIT);
    assign active    = (h_pos >= H_LO) && (h_pos <= H_HI) &&
                       (l_pos >= V_LO) && (l_pos <= V_HI);

    assign locked = (state == LOCKED);

    // Lock FSM, watchdog, checksum and frame reporting
    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= SEARCH;
            frame_ok   <= 1'b0;
            h_valid    <= 1'b0;
            sum        <= '0;
            wd         <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (pix_en) begin
                if (h_rise)
                    wd <= '0;
                else if (wd != WD_MAX)
                    wd <= wd + WDW'(1);
                if (h_rise)
                    h_valid <= 1'b1;
                if (active && state != SEARCH)
                    sum <= sum + {4'b0, red, green, blue};
                unique case (state)
                    SEARCH: begin
                        sum     <= '0;
                        h_valid <= 1'b0;
                        if (v_rise && !wd_hit) begin
                            state    <= MEASURE;
                            frame_ok <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (wd_hit) begin
                            state   <= SEARCH;
                            sum     <= '0;
                            h_valid <= 1'b0;
                        end else begin
                            if (meas_bad)
                                frame_ok <= 1'b0;
                            if (v_rise) begin
                                frame_ok <= 1'b1;
                                sum      <= '0;
                                if (frame_ok && !meas_bad && !vt_bad)
                                    state <= LOCKED;
                            end
                        end
                    end
                    LOCKED: begin
                        if (wd_hit || meas_bad || vt_bad) begin
                            state   <= SEARCH;
                            sum     <= '0;
                            h_valid <= 1'b0;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end else if (v_rise) begin
                            frame_sum  <= sum;
                            sum        <= '0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state   <= SEARCH;
                        sum     <= '0;
                        h_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a scaled-down
// video mode so several whole frames fit in a short run.
module tb_vga_sync_monitor;

    localparam int HT = 40;
    localparam int HS = 4;
    localparam int HB = 6;
    localparam int HA = 24;
    localparam int VT = 20;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 12;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  red = '0;
    logic [3:0]  green = '0;
    logic [3:0]  blue = '0;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [15:0] frame_cnt;
    logic [10:0] h_total_meas;
    logic [10:0] hs_width_meas;
    logic [9:0]  v_total_meas;
    logic [9:0]  vs_width_meas;
    logic [7:0]  err_cnt;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .SYNC_POL(1'b0)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .pix_en        (pix_en),
        .hsync         (hsync),
        .vsync         (vsync),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .locked        (locked),
        .frame_done    (frame_done),
        .frame_sum     (frame_sum),
        .frame_cnt     (frame_cnt),
        .h_total_meas  (h_total_meas),
        .hs_width_meas (hs_width_meas),
        .v_total_meas  (v_total_meas),
        .vs_width_meas (vs_width_meas),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic [15:0] cnt;
        logic [7:0]  err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   div = 1;
    int   pat = 0;
    int   err_exp = 0;
    logic fd_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [15:0] s,
                                input int c, input int e);
        q.push_back({s, 16'(c), 8'(e)});
    endtask

    // One sample: pix_en high for one clk, low for div-1 clks
    task automatic send(input logic hs, input logic vs,
                        input logic [11:0] rgb);
        hsync = hs;
        vsync = vs;
        {red, green, blue} = rgb;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        for (int i = 1; i < div; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [11:0] pix(input int h, input int v);
        if (pat == 0)
            return 12'h001;
        return 12'(h * 37 + v * 101);
    endfunction

    // Render one frame; optionally stretch a line or pulse clr
    task automatic frame(input int stretch, input int rst_line,
                         output logic [15:0] fsum);
        int          len;
        logic        hs;
        logic        vs;
        logic        act;
        logic [11:0] rgb;
        fsum = '0;
        for (int v = 0; v < VT; v++) begin
            len = (v == stretch) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                hs  = (h < HS) ? 1'b0 : 1'b1;
                vs  = (v < VS) ? 1'b0 : 1'b1;
                act = (h >= HS + HB) && (h < HS + HB + HA) &&
                      (v >= VS + VB) && (v < VS + VB + VA);
                rgb = act ? pix(h, v) : 12'hFFF;
                if (act)
                    fsum = fsum + {4'b0, rgb};
                if (v == rst_line && h == 10) begin
                    clr = 1'b0;
                    send(hs, vs, rgb);
                    clr = 1'b1;
                    chk("midframe_rst_sum_cnt",
                        {frame_sum, frame_cnt}, 0);
                    chk("midframe_rst_status",
                        {locked, frame_done, err_cnt, h_total_meas,
                         hs_width_meas, v_total_meas, vs_width_meas},
                        0);
                end else begin
                    send(hs, vs, rgb);
                end
                if (v == stretch && h == HT)
                    chk("locked_before_bad_edge", locked, 1);
                if (stretch >= 0 && v == stretch + 1 && h == 0) begin
                    chk("unlock_on_bad_edge", locked, 0);
                    chk("err_after_stretch", err_cnt, err_exp);
                end
            end
        end
    endtask

    // Scoreboard monitor: pop expected record on each frame_done
    always @(negedge clk) begin
        if (fd_prev)
            chk("frame_done_width", frame_done, 0);
        fd_prev <= frame_done;
        if (frame_done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_frame_done: cnt %0d",
                         frame_cnt);
            end else begin
                mon_e = q.pop_front();
                chk("frame_sum", frame_sum, mon_e.sum);
                chk("frame_cnt", frame_cnt, mon_e.cnt);
                chk("err_at_done", err_cnt, mon_e.err);
                chk("locked_at_done", locked, 1);
                chk("h_total_at_done", h_total_meas, HT);
                chk("v_total_at_done", v_total_meas, VT);
            end
        end
    end

    initial begin
        logic [15:0] s0, s1, s2, s3, s4, s5, s6, s7;
        logic [15:0] s8, s9, s10, s11, s12, s13, s14;

        clr = 1'b0;
        repeat (3) send(1'b1, 1'b1, 12'h0);
        chk("reset_sum_cnt", {frame_sum, frame_cnt}, 0);
        chk("reset_status",
            {locked, frame_done, err_cnt, h_total_meas,
             hs_width_meas, v_total_meas, vs_width_meas}, 0);
        clr = 1'b1;
        repeat (5) send(1'b1, 1'b1, 12'h0);
        chk("idle_not_locked", locked, 0);

        frame(-1, -1, s0);
        chk("measure_not_locked", locked, 0);
        chk("meas_h_total", h_total_meas, HT);
        chk("meas_hs_width", hs_width_meas, HS);
        chk("meas_vs_width", vs_width_meas, VS);

        frame(-1, -1, s1);
        chk("locked_2nd_edge", locked, 1);
        chk("meas_v_total", v_total_meas, VT);
        chk("err_nominal", err_cnt, 0);

        expect_frame(s1, 1, 0);
        frame(-1, -1, s2);
        pat = 1;
        expect_frame(s2, 2, 0);
        frame(-1, -1, s3);

        err_exp = 1;
        expect_frame(s3, 3, 0);
        frame(5, -1, s4);
        chk("after_stretch_unlocked", locked, 0);
        frame(-1, -1, s5);
        chk("relock_measure", locked, 0);
        frame(-1, -1, s6);
        chk("relock_locked", locked, 1);
        chk("relock_err", err_cnt, 1);

        expect_frame(s6, 4, 1);
        frame(-1, -1, s7);

        repeat (40) send(1'b1, 1'b1, 12'h0);
        chk("wd_before_trip", locked, 1);
        send(1'b1, 1'b1, 12'h0);
        chk("wd_trip_unlock", locked, 0);
        chk("wd_trip_err", err_cnt, 2);

        frame(-1, 8, s8);
        frame(-1, -1, s9);
        chk("post_rst_measure", locked, 0);
        frame(-1, -1, s10);
        chk("post_rst_locked", locked, 1);
        chk("post_rst_cnt", frame_cnt, 0);

        expect_frame(s10, 1, 0);
        frame(-1, -1, s11);
        div = 4;
        expect_frame(s11, 2, 0);
        frame(-1, -1, s12);
        pat = 0;
        expect_frame(s12, 3, 0);
        frame(-1, -1, s13);
        expect_frame(s13, 4, 0);
        frame(-1, -1, s14);
        chk("div4_h_total", h_total_meas, HT);
        chk("div4_hs_width", hs_width_meas, HS);
        chk("div4_v_total", v_total_meas, VT);
        chk("div4_vs_width", vs_width_meas, VS);
        chk("div4_locked", locked, 1);

        repeat (8) @(posedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
